// File: rtl/mux_scan_ctrl_pkg.sv
// mux_scan_ctrl_pkg
//   Shared definitions for the mux scan controller: FSM state encoding,
//   channel count, select width, terminal select value and a parity helper.
//   Optional feature macro used by the controller: SCAN_PARITY_EN.
package mux_scan_ctrl_pkg;

   localparam int unsigned NUM_CH = 8;
   localparam int unsigned SEL_W  = 3;

   localparam logic [SEL_W-1:0] SEL_LAST = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_SAMPLE = 2'd2,
      ST_DONE   = 2'd3
   } state_e;

   function automatic logic word_parity(input logic [NUM_CH-1:0] w);
      return ^w;
   endfunction

endpackage

// File: rtl/mux_scan_ctrl_sel_counter.sv
// scan_sel_counter
//   3-bit select counter for the mux scan. Clear has priority over increment;
//   the count saturates at SEL_LAST so it never passes the last channel.
//   Ports:
//     clk, reset   clock, asynchronous active-high reset
//     clr_i        force count to 0
//     inc_i        advance count by one (ignored at the terminal value)
//     sel_o        current select value
//     last_o       high when sel_o is the terminal value
module scan_sel_counter
   import mux_scan_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             reset,
   input  logic             clr_i,
   input  logic             inc_i,
   output logic [SEL_W-1:0] sel_o,
   output logic             last_o
);

   logic [SEL_W-1:0] sel_q;
   logic [SEL_W-1:0] sel_d;

   always_comb begin
      sel_d = sel_q;
      if (clr_i) begin
         sel_d = '0;
      end else if (inc_i && (sel_q != SEL_LAST)) begin
         sel_d = sel_q + 3'd1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sel_q <= '0;
      end else begin
         sel_q <= sel_d;
      end
   end

   assign sel_o  = sel_q;
   assign last_o = (sel_q == SEL_LAST);

endmodule

// File: rtl/mux_scan_ctrl.sv
// mux_scan_ctrl
//   Scan controller for an 8:1 mux tree. On start it steps the select through
//   all eight channels, captures mux_out into bit sel of a word, then presents
//   the complete word on data with a one-cycle done pulse.
//   Parameter:
//     SETTLE_CYCLES  idle cycles after each select change before sampling (0..15)
//   Ports:
//     clk      clock, rising edge
//     reset    asynchronous active-high reset
//     start    scan request, sampled only in IDLE
//     mux_out  output of the mux tree
//     sel      registered select to the mux tree
//     busy     high from start acceptance until done
//     done     one-cycle pulse, data valid
//     data     last completed scan word
//     parity   XOR of the completed word (only with SCAN_PARITY_EN defined)
module mux_scan_ctrl
   import mux_scan_ctrl_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              mux_out,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done,
   output logic [NUM_CH-1:0] data
`ifdef SCAN_PARITY_EN
   ,
   output logic              parity
`endif
);

   localparam bit          HAS_SETTLE    = (SETTLE_CYCLES != 0);
   localparam int unsigned SETTLE_LAST_I = HAS_SETTLE ? SETTLE_CYCLES - 1 : 0;
   localparam logic [3:0]  SETTLE_LAST   = SETTLE_LAST_I[3:0];

   state_e            state_q, state_d;
   logic [3:0]        settle_q, settle_d;
   logic [NUM_CH-1:0] capture_q, capture_d;
   logic [NUM_CH-1:0] data_q, data_d;
   logic              sel_clr, sel_inc, sel_last;
   logic [SEL_W-1:0]  sel_cur;

   scan_sel_counter u_sel_counter (
      .clk    (clk),
      .reset  (reset),
      .clr_i  (sel_clr),
      .inc_i  (sel_inc),
      .sel_o  (sel_cur),
      .last_o (sel_last)
   );

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
         end
         ST_SETTLE: begin
            if (settle_q == SETTLE_LAST) state_d = ST_SAMPLE;
         end
         ST_SAMPLE: begin
            if (sel_last) state_d = ST_DONE;
            else          state_d = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output / datapath control
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      sel_clr   = 1'b0;
      sel_inc   = 1'b0;
      settle_d  = settle_q;
      capture_d = capture_q;
      data_d    = data_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               sel_clr   = 1'b1;
               capture_d = '0;
               settle_d  = '0;
            end
         end
         ST_SETTLE: begin
            busy     = 1'b1;
            settle_d = (settle_q == SETTLE_LAST) ? 4'd0 : settle_q + 4'd1;
         end
         ST_SAMPLE: begin
            busy             = 1'b1;
            capture_d[sel_cur] = mux_out;
            // data is published only with the final bit merged in, so it never
            // shows a partial word
            if (sel_last) data_d = capture_d;
            else          sel_inc = 1'b1;
         end
         ST_DONE: begin
            done    = 1'b1;
            sel_clr = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         settle_q  <= '0;
         capture_q <= '0;
         data_q    <= '0;
      end else begin
         settle_q  <= settle_d;
         capture_q <= capture_d;
         data_q    <= data_d;
      end
   end

   assign sel  = sel_cur;
   assign data = data_q;

`ifdef SCAN_PARITY_EN
   logic parity_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         parity_q <= 1'b0;
      end else if ((state_q == ST_SAMPLE) && sel_last) begin
         parity_q <= word_parity(capture_d);
      end
   end

   assign parity = parity_q;
`endif

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// tb_mux_scan_ctrl
//   Two controllers (settle 0 and settle 2) each read a behavioural 8:1 mux.
//   Expected words and timing come from the scan rules: channel k is captured
//   from the mux value during cycle (k+1)(S+1)-1 after acceptance, done is high
//   in cycle 8(S+1).
module tb_mux_scan_ctrl;

   localparam int unsigned S0 = 0;
   localparam int unsigned S1 = 2;

   logic       clk = 1'b0;
   logic       rst;
   logic       start_i  [2];
   logic [7:0] mux_in   [2];
   logic       mux_out  [2];
   logic [2:0] sel_o    [2];
   logic       busy_o   [2];
   logic       done_o   [2];
   logic [7:0] data_o   [2];
`ifdef SCAN_PARITY_EN
   logic       parity_o [2];
`endif

   logic [7:0] last_data [2];
   int         checks = 0;
   int         errors = 0;

   always #5 clk = ~clk;

   assign mux_out[0] = mux_in[0][sel_o[0]];
   assign mux_out[1] = mux_in[1][sel_o[1]];

   mux_scan_ctrl #(.SETTLE_CYCLES(S0)) u_dut0 (
      .clk     (clk),
      .reset   (rst),
      .start   (start_i[0]),
      .mux_out (mux_out[0]),
      .sel     (sel_o[0]),
      .busy    (busy_o[0]),
      .done    (done_o[0]),
      .data    (data_o[0])
`ifdef SCAN_PARITY_EN
      ,
      .parity  (parity_o[0])
`endif
   );

   mux_scan_ctrl #(.SETTLE_CYCLES(S1)) u_dut1 (
      .clk     (clk),
      .reset   (rst),
      .start   (start_i[1]),
      .mux_out (mux_out[1]),
      .sel     (sel_o[1]),
      .busy    (busy_o[1]),
      .done    (done_o[1]),
      .data    (data_o[1])
`ifdef SCAN_PARITY_EN
      ,
      .parity  (parity_o[1])
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic chk_idle(input int i);
      chk($sformatf("idle_sel%0d", i),  32'(sel_o[i]),  32'd0);
      chk($sformatf("idle_busy%0d", i), 32'(busy_o[i]), 32'd0);
      chk($sformatf("idle_done%0d", i), 32'(done_o[i]), 32'd0);
      chk($sformatf("idle_data%0d", i), 32'(data_o[i]), 32'(last_data[i]));
`ifdef SCAN_PARITY_EN
      chk($sformatf("idle_par%0d", i), 32'(parity_o[i]), 32'(^last_data[i]));
`endif
   endtask

   // One full scan on instance i. pre=1: the start was already accepted at the
   // previous edge. chg_t: cycle after acceptance at which mux input becomes w1.
   // poke: random start activity while busy/done. hold_after: start high in the
   // idle cycle after done, so the next scan is accepted straight away.
   task automatic scan(input int i, input logic [7:0] w0, input int chg_t,
                       input logic [7:0] w1, input bit poke, input bit hold_after,
                       input bit pre);
      int         s;
      int         last;
      logic [7:0] expw;
      s    = (i == 0) ? int'(S0) : int'(S1);
      last = 8 * (s + 1);
      expw = '0;
      if (!pre) begin
         start_i[i] = 1'b1;
         tick();
      end
      for (int t = 0; t <= last + 1; t++) begin
         if (t == 0)     mux_in[i] = w0;
         if (t == chg_t) mux_in[i] = w1;
         if (t < last) begin
            chk($sformatf("scan_sel%0d_t%0d", i, t), 32'(sel_o[i]), 32'(t / (s + 1)));
            chk($sformatf("scan_busy%0d_t%0d", i, t), 32'(busy_o[i]), 32'd1);
            chk($sformatf("scan_done%0d_t%0d", i, t), 32'(done_o[i]), 32'd0);
            chk($sformatf("scan_data%0d_t%0d", i, t), 32'(data_o[i]), 32'(last_data[i]));
            if (((t + 1) % (s + 1)) == 0) begin
               int k;
               k = (t + 1) / (s + 1) - 1;
               expw[k] = mux_in[i][k];
            end
         end else if (t == last) begin
            chk($sformatf("done_pulse%0d", i), 32'(done_o[i]), 32'd1);
            chk($sformatf("done_busy%0d", i),  32'(busy_o[i]), 32'd0);
            chk($sformatf("done_data%0d", i),  32'(data_o[i]), 32'(expw));
`ifdef SCAN_PARITY_EN
            chk($sformatf("done_par%0d", i), 32'(parity_o[i]), 32'(^expw));
`endif
            last_data[i] = expw;
         end else begin
            chk_idle(i);
         end
         if (t <= last) start_i[i] = poke ? 1'($urandom_range(0, 1)) : 1'b0;
         else           start_i[i] = hold_after;
         tick();
      end
      chk($sformatf("post_busy%0d", i), 32'(busy_o[i]), 32'(hold_after));
   endtask

   initial begin
      rst          = 1'b1;
      start_i[0]   = 1'b0;
      start_i[1]   = 1'b0;
      mux_in[0]    = '0;
      mux_in[1]    = '0;
      last_data[0] = '0;
      last_data[1] = '0;
      tick();
      tick();
      rst = 1'b0;

      // Idle after reset
      for (int n = 0; n < 4; n++) begin
         chk_idle(0);
         chk_idle(1);
         tick();
      end

      // Basic scans, S=0 and S=2
      scan(0, 8'hA5, -1, 8'h00, 1'b0, 1'b0, 1'b0);
      scan(1, 8'h01, -1, 8'h00, 1'b0, 1'b0, 1'b0);

      // Start activity while busy / in DONE, inputs change mid-scan,
      // then a held start launches a scan of the new value
      scan(0, 8'hA5, 3, 8'h3C, 1'b1, 1'b1, 1'b0);
      scan(0, 8'h3C, -1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Asynchronous reset between edges at sel=4
      start_i[0] = 1'b1;
      mux_in[0]  = 8'h77;
      tick();
      start_i[0] = 1'b0;
      repeat (4) tick();
      chk("pre_reset_sel", 32'(sel_o[0]), 32'd4);
      #2;
      rst = 1'b1;
      #1;
      last_data[0] = '0;
      last_data[1] = '0;
      chk_idle(0);
      chk_idle(1);
      tick();
      chk_idle(0);
      rst = 1'b0;
      tick();
      chk_idle(0);
      chk_idle(1);
      scan(0, 8'hFF, -1, 8'h00, 1'b0, 1'b0, 1'b0);

      // Back-to-back scans with start held
      scan(0, 8'h5A, -1, 8'h00, 1'b0, 1'b1, 1'b0);
      scan(0, 8'hC3, -1, 8'h00, 1'b0, 1'b0, 1'b1);

      // Randomized scans on both instances
      for (int r = 0; r < 6; r++) begin
         int         i;
         int         chg;
         logic [7:0] a;
         logic [7:0] b;
         i   = int'($urandom_range(0, 1));
         a   = 8'($urandom);
         b   = 8'($urandom);
         chg = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, (i == 0) ? 7 : 23)) : -1;
         scan(i, a, chg, b, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential scan controller that sits directly upstream of the 8:1 mux tree, driving its 3-bit select and sampling its single-bit output. On a start request it walks the select through all eight channels, captures each sampled bit into position `sel` of an 8-bit word, and presents the complete word with a one-cycle `done` pulse. The mux tree plus this controller form a parallel-in, serial-through, parallel-out loop used to exercise and read back the mux channels.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 0: idle cycles inserted after each select change before sampling; legal range 0–15.

Ports:
- `clk`  input  1  single clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high; clears all state immediately.
- `start`  input  1  scan request; sampled only in IDLE.
- `mux_out`  input  1  output of the 8:1 mux tree.
- `sel`  output  3  select driven to the mux tree.
- `busy`  output  1  high from start acceptance until `done` is asserted.
- `done`  output  1  one-cycle pulse; `data` is valid and complete.
- `data`  output  8  last completed scan word; `data[i]` is the value of channel i.
- `parity`  output  1  present only with `SCAN_PARITY_EN`.

## Operation
- Reset values: state IDLE, `sel`=0, `busy`=0, `done`=0, `data`=8'h00, internal capture register=0, settle counter=0, `parity`=0.
- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: when `start`=1, clear the capture register, set `sel`=0, and set `busy`=1. Go to SETTLE if `SETTLE_CYCLES`>0, else SAMPLE.
- SETTLE: count `SETTLE_CYCLES` cycles, then go to SAMPLE.
- SAMPLE: write `capture[sel]` <= `mux_out`.
  - If `sel`==7: load `data` <= the full capture word including this bit, set `busy`=0, and go to DONE.
  - Otherwise: `sel` <= `sel`+1 and return to SETTLE or SAMPLE.
- DONE: `done`=1 for exactly this cycle, then go to IDLE. `sel` returns to 0.
- `start` is ignored while `busy`=1 and during DONE. A request must be held or reissued and is accepted in the next IDLE cycle.
- `data` changes only on the SAMPLE→DONE transition, so it is stable between scans and never shows a partial word.
- `sel` does not wrap during a scan. 7 is terminal; the counter never passes 7.
- Reset mid-scan aborts immediately. No `done` is produced, and `data` returns to 0.

## Timing
- Start accepted at edge N. With `SETTLE_CYCLES`=S, channel k is sampled at edge N+(k+1)(S+1).
- `done` is high during the cycle after edge N+8(S+1). With S=0, channel 0 is sampled at N+1, channel 7 at N+8, and `done` is high in the cycle after N+8.
- Back-to-back scans: the earliest re-acceptance is at edge N+8(S+1)+2 (DONE, then IDLE).
- `sel` is registered and glitch-free. `mux_out` is treated as combinational from `sel` and must settle within one cycle when S=0.

## Configuration
- `SCAN_PARITY_EN` defined:
  - Adds output `parity` = XOR of all 8 bits of the completed word.
  - It is registered and loaded in the same cycle as `data`, with reset value 0.
  - Result: odd number of ones → 1.
- `SCAN_PARITY_EN` not defined: no `parity` port and no parity logic.

## Structure
- The shared include header holds:
  - state encodings (IDLE=2'd0, SETTLE=2'd1, SAMPLE=2'd2, DONE=2'd3);
  - channel count 8 and select width 3;
  - the terminal select value 3'd7.
- One natural sub-module, `scan_sel_counter`: the 3-bit select counter with clear, increment, and terminal-count flag. The FSM and capture register stay in `mux_scan_ctrl`.

## Test plan
- Reset, then idle with `start`=0 → `sel`=0, `busy`=0, `done`=0, `data`=8'h00 held indefinitely.
- Bench mux tree driven with inputs 8'hA5, S=0, one-cycle `start` → `sel` steps 0..7 on consecutive edges; `done` is high exactly one cycle, 9 cycles after acceptance; `data`=8'hA5; `parity`=0 if enabled.
- Inputs 8'h01 with S=2 → each `sel` value is held 3 cycles; `done` comes 25 cycles after acceptance; `data`=8'h01; `parity`=1.
- `start` pulsed while busy and during DONE, with inputs changed to 8'h3C mid-scan → no second scan starts; the current scan captures channels according to the inputs at each sample edge. A held `start` then launches a new scan returning 8'h3C.
- Asynchronous reset asserted mid-scan, between clock edges, at `sel`=4 → outputs clear immediately with no `done`. After release, a full scan of 8'hFF returns `data`=8'hFF.
- Two back-to-back scans with `start` held high, inputs 8'h5A then 8'hC3 → the second is accepted at N+10 (S=0). `data` reads 8'h5A until the second `done`, then 8'hC3.
